// File: rtl/en_strobe_pkg.sv
// Shared types for the enable-strobe generator: FSM state encoding and mode constants.
package en_strobe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/mod_counter.sv
// Up-counter that wraps to zero after reaching a terminal value; tc flags the terminal count.
module mod_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = (count == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/en_strobe_gen.sv
// Periodic one-cycle enable strobe generator with continuous and burst (one-shot) modes.
//   state   | meaning
//   IDLE    | waiting for start; settings captured on start
//   RUN     | period counter running, en pulses every div+1 cycles
//   DONE    | one-cycle burst-complete indication, then IDLE
module en_strobe_gen
  import en_strobe_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst_len,
  output logic             en,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] pulse_cnt;
  logic             mode_q;
  logic             per_tc;

  // A zero burst length still produces one strobe.
  assign len_eff = (len_q == '0) ? CNT_W'(1) : len_q;

  mod_counter #(.W(DIV_W)) u_period (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != ST_RUN),
    .inc  (state == ST_RUN),
    .term (div_q),
    .tc   (per_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_q     <= '0;
      len_q     <= '0;
      mode_q    <= MODE_CONT;
      pulse_cnt <= '0;
    end else begin
      en   <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            div_q     <= div;
            len_q     <= burst_len;
            mode_q    <= mode;
            pulse_cnt <= '0;
          end
        end
        ST_RUN: begin
          // The last burst strobe has already been issued when the count matches,
          // so DONE starts the cycle after that strobe and en never overlaps it.
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (mode_q == MODE_BURST && pulse_cnt == len_eff) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (per_tc) begin
            en <= 1'b1;
            if (mode_q == MODE_BURST) pulse_cnt <= pulse_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_en_strobe_gen.sv
// Directed self-checking bench for en_strobe_gen, including a downstream clock-enabled flop.
module tb_en_strobe_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, mode;
  logic [7:0] div, burst_len;
  logic       en, busy, done;
  logic       d, q;
  logic       en_cur, q_exp;
  int         checks = 0;
  int         failures = 0;

  en_strobe_gen #(.DIV_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .div       (div),
    .burst_len (burst_len),
    .en        (en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Downstream flop: d toggles every cycle, q follows only when en is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= 1'b0;
      q <= 1'b0;
    end else begin
      d <= ~d;
      if (en) q <= d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_en, input logic e_busy, input logic e_done);
    chk({tag, "_en"}, en, e_en);
    chk({tag, "_busy"}, busy, e_busy);
    chk({tag, "_done"}, done, e_done);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; div = 8'd0; burst_len = 8'd0;
    tick(); tick();
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("idle_after_reset", 1'b0, 1'b0, 1'b0);

    // Continuous, div=3, with a mid-run div change and start re-pulse; downstream flop tracked.
    div = 8'd3; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("cont_start", 1'b0, 1'b1, 1'b0);
    en_cur = 1'b0; q_exp = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (en_cur) q_exp = d;
      tick();
      en_cur = (k % 4 == 0);
      chk_out($sformatf("cont_k%0d", k), en_cur, 1'b1, 1'b0);
      chk($sformatf("flop_q_k%0d", k), q, q_exp);
      if (k == 6) begin div = 8'd7; start = 1'b1; end
      if (k == 7) start = 1'b0;
    end
    // Stop exactly where the 12th-cycle pulse would be due.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("cont_stop", 1'b0, 1'b0, 1'b0);
    chk("flop_q_stop", q, q_exp);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out($sformatf("after_stop_%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // Burst: div=1, burst_len=3 -> en on cycles 2,4,6, done on 7.
    div = 8'd1; burst_len = 8'd3; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("burst_start", 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_out($sformatf("burst_k%0d", k), (k % 2 == 0), 1'b1, 1'b0);
    end
    tick();
    chk_out("burst_done", 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("burst_idle", 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("burst_idle2", 1'b0, 1'b0, 1'b0);

    // div=0, burst_len=0: single strobe on first RUN cycle, then done.
    div = 8'd0; burst_len = 8'd0; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("zero_start", 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("zero_pulse", 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("zero_done", 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("zero_idle", 1'b0, 1'b0, 1'b0);

    // start and stop together in IDLE: nothing happens.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk_out("start_stop_idle", 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk_out("start_stop_idle2", 1'b0, 1'b0, 1'b0);

    // Burst completion coinciding with stop: stop wins, no done.
    div = 8'd0; burst_len = 8'd1; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_out("cmpl_stop_pulse", 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("cmpl_stop", 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("cmpl_stop_after", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset during RUN with div=3, taken while en is high.
    div = 8'd3; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    chk_out("rst_run_pre", 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("rst_run_async", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out($sformatf("rst_run_idle_%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset while done is high: no done after release.
    div = 8'd0; burst_len = 8'd0; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk_out("rst_done_pre", 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_out("rst_done_async", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("rst_done_idle_%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // div all-ones: first strobe after 256 edges, none before.
    div = 8'hFF; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 257; k++) begin
      tick();
      chk($sformatf("divmax_en_k%0d", k), en, (k == 256));
    end
    chk("divmax_busy", busy, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("divmax_stop", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/en_strobe_gen.md
EN_STROBE_GEN -- requirements
Module: en_strobe_gen

Interface
REQ-001 Parameter: DIV_W, 8, width of the divide-ratio input and internal period counter.
REQ-002 Parameter: CNT_W, 8, width of the burst-length input and pulse counter.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  begin generating strobes, sampled at clk rising edge.
REQ-006 Port: stop  input  1  abort generation, sampled at clk rising edge.
REQ-007 Port: mode  input  1  0 = continuous, 1 = burst (one-shot).
REQ-008 Port: div  input  DIV_W  period select; strobe period = div+1 cycles.
REQ-009 Port: burst_len  input  CNT_W  number of strobes in burst mode; 0 treated as 1.
REQ-010 Port: en  output  1  registered one-cycle enable strobe, drives downstream clock-enabled flops.
REQ-011 Port: busy  output  1  registered, high while in RUN.
REQ-012 Port: done  output  1  registered, one-cycle pulse when a burst completes normally.

Function
REQ-013 FSM states: IDLE, RUN, DONE; encoding defined in the shared package.
REQ-014 IDLE: start=1 and stop=0 at an edge -> RUN; div, mode, burst_len captured into internal registers at that edge; period counter and pulse counter cleared to 0.
REQ-015 Captured values are used for the whole run; input changes during RUN have no effect.
REQ-016 RUN: period counter increments each cycle; when it equals captured div, en=1 for exactly that one cycle and the counter wraps to 0.
REQ-017 Latency: first en pulse is high in the cycle starting div+1 edges after the edge that sampled start; subsequent pulses every div+1 cycles.
REQ-018 div=0: en high on every RUN cycle, starting one edge after start is sampled.
REQ-019 div = all-ones: period 2^DIV_W cycles, no counter overflow beyond wrap to 0.
REQ-020 Continuous mode: RUN persists until stop or reset.
REQ-021 Burst mode: pulse counter increments on each en; after the Nth pulse (N = captured burst_len, or 1 if 0) the next state is DONE.
REQ-022 DONE: lasts exactly one cycle, done=1, en=0, busy=0; then IDLE unconditionally.
REQ-023 stop=1 in RUN: next state IDLE, no en issued at that edge even if a pulse was due, done stays 0.
REQ-024 start and stop both high in IDLE: stop wins, remains IDLE.
REQ-025 start while in RUN or DONE: ignored; no restart, counters unaffected.
REQ-026 busy=1 exactly while the state is RUN; en never high outside RUN.
REQ-027 Burst completion and stop at the same edge: stop wins, IDLE, no done.

Reset
REQ-028 rst=1 forces asynchronously: state IDLE, en=0, busy=0, done=0, all counters and captured registers 0.
REQ-029 Reset asserted mid-run or mid-DONE aborts immediately; no done pulse follows release.
REQ-030 After rst deasserts, the block waits in IDLE for a new start.

Structure
REQ-031 Shared package en_strobe_pkg holds the state type/encoding and MODE_CONT=0 / MODE_BURST=1 constants.
REQ-032 One sub-module, mod_counter (parameterised width, clear, wrap-at-terminal-value, terminal flag), instantiated for the period counter.
REQ-033 Outputs en, busy, done come directly from flops; no combinational input-to-output path.

Verification
REQ-034 Reset: rst=1 during RUN with div=3 -> en, busy, done go 0 immediately, with no clock edge required; IDLE after release.
REQ-035 Continuous: div=3, mode=0, start pulse -> en high every 4th cycle, first pulse 4 edges after start; stop -> busy drops next edge, no further en.
REQ-036 Burst: div=1, burst_len=3, mode=1 -> exactly 3 en pulses 2 cycles apart, then done=1 for one cycle, busy=0, state IDLE.
REQ-037 Edges: div=0, burst_len=0 -> one en on the first RUN cycle, then done; start+stop together in IDLE -> nothing happens.
REQ-038 Stability: change div from 3 to 7 mid-run and pulse start again -> period stays 4, no restart.
REQ-039 Downstream: en drives a clock-enabled D flop with D toggling every cycle -> Q updates only on cycles where en=1.
